srm_controller: RTL and testbench
=================================

Name: srm_controller

Overview:
- Instruction-sequencing FSM for the Simple RISC Machine datapath. It drives the register file, the A/B/C pipeline registers and the ALU operation select.
- It captures the Z/N/V status the ALU returns into a 3-bit status register.
- It sits between the instruction register and the datapath, on the control/consumer side of the ALU's ALUop and status interface.

Parameters:
- None. The design is fixed at a 3-bit opcode and a 2-bit op field.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- s  input  1  start; sampled only in WAIT
- opcode  input  3  instruction bits [15:13]
- op  input  2  instruction bits [12:11]
- Z_in, N_in, V_in  input  1 each  ALU status outputs
- w  output  1  high in WAIT (ready for next instruction)
- nsel  output  3  one-hot register-field select: 001 Rn, 010 Rd, 100 Rm, 000 none
- vsel  output  2  writeback source: 00 C, 10 sign-extended imm8; 00 when idle
- loada, loadb, loadc, loads, write  output  1 each  load strobes
- asel  output  1  1 forces ALU A operand to 0
- bsel  output  1  1 selects imm; always 0 for the supported instructions
- ALUop  output  2  00 ADD, 01 SUB, 10 AND, 11 NOT B
- Z_out, N_out, V_out  output  1 each  registered status flags

Behaviour:
- All outputs are Moore outputs, decoded from the state register. Only Z/N/V_out are separately registered.
- Reset: on the first clk edge with reset=1, state goes to WAIT and Z/N/V_out go to 000.
  - Outputs in WAIT: w=1; nsel=000; vsel=00; ALUop=00; all strobes, asel and bsel are 0.
  - Reset wins over every other condition, including mid-instruction. No write occurs on the edge where reset=1.
- Decoded instructions:
  - MOVI: opcode 110, op 10
  - MOV: opcode 110, op 00
  - ADD / CMP / AND / MVN: opcode 101, op 00 / 01 / 10 / 11
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM.
- WAIT:
  - If s=1, latch opcode and op into internal registers and go to DECODE.
  - Later changes on the opcode/op inputs are ignored until the next WAIT.
- DECODE, all outputs idle:
  - MOVI → WRITE_IMM
  - MOV or MVN → GET_B
  - ADD, CMP or AND → GET_A
  - any other encoding → WAIT (treated as a no-op; no strobes issued)
- GET_A: nsel=001, loada=1 → GET_B.
- GET_B: nsel=100, loadb=1 → EXEC.
- EXEC: loadc=1.
  - ALUop = latched op for opcode 101, and 00 for MOV.
  - asel=1 for MOV only.
  - CMP: loads=1 instead of loadc=1; the status register captures Z_in/N_in/V_in at the end of this cycle. Next state WAIT (no writeback).
  - Otherwise → WRITE_REG.
- WRITE_REG: nsel=010, vsel=00, write=1 → WAIT.
- WRITE_IMM: nsel=001, vsel=10, write=1 → WAIT.
- The status register updates only on the edge ending a CMP EXEC cycle. ADD, AND, MVN and MOV leave Z/N/V_out unchanged.
- Latency, counted from the edge that samples s=1 to the edge returning to WAIT (w high one cycle later than WRITE):
  - MOVI: 2 edges
  - MOV and MVN: 4 edges
  - ADD and AND: 5 edges
  - CMP: 4 edges
- s=1 outside WAIT is ignored. s held high in WAIT starts back-to-back instructions with no idle cycle beyond the one WAIT cycle.
- Exactly one of write, loads or loadc-then-write ends each valid instruction. write is never asserted in the same cycle as loada, loadb or loadc.

Decomposition:
- Shared package `srm_pkg`. It holds:
  - opcode and op localparams (OPC_MOV=3'b110, OPC_ALU=3'b101, ALU_ADD..ALU_MVN)
  - state enum typedef
  - NSEL_RN/RD/RM and VSEL_C/VSEL_IMM constants
- One natural sub-module, `srm_status_reg`: a 3-bit load-enable register with synchronous reset, shared with future branch logic.

Test Plan:
- Reset mid-GET_B of an ADD (reset after 3rd edge) → next edge w=1, all strobes 0, Z/N/V_out=000, no write pulse ever seen.
- MOVI (opcode 110, op 10, s pulsed 1 cycle) → DECODE; then WRITE_IMM with nsel=001, vsel=10, write=1; w=1 on the following cycle; total 2 edges, no loada/loadb.
- ADD (101/00) → per-cycle sequence:
  - loada with nsel=001
  - loadb with nsel=100
  - loadc with ALUop=00, asel=0
  - write with nsel=010, vsel=00
  - Z/N/V_out unchanged from 000.
- CMP with Z_in=0, N_in=1, V_in=1 during EXEC → loads=1, no write; Z/N/V_out=011 one edge later; w=1 after 4 edges.
- MOV (110/00), with opcode changed to 111 after start → still follows GET_B, then EXEC (asel=1, ALUop=00), then WRITE_REG; latched opcode used.
- Illegal opcode 000 with s=1 → DECODE then WAIT, no strobes. s held high across a MVN produces no restart until WAIT, then immediate new DECODE.

Source files
------------

// File: rtl/srm_pkg.sv
// Shared encodings for the Simple RISC Machine control path: opcodes, ALU ops,
// controller states and the register/writeback select codes.
package srm_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_t;

endpackage

// File: rtl/srm_status_reg.sv
// Load-enable status flag register with synchronous reset; one flop per bit so
// branch logic can later reuse it at other widths.
module srm_status_reg #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic bit_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          bit_reg <= 1'b0;
        end else if (load) begin
          bit_reg <= d[gi];
        end
      end

      assign q[gi] = bit_reg;
    end
  endgenerate

endmodule

// File: rtl/srm_controller.sv
// Instruction-sequencing FSM for the Simple RISC Machine datapath. Outputs are
// Moore-decoded from the state and the instruction fields latched in WAIT.
module srm_controller
  import srm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic       Z_in,
  input  logic       N_in,
  input  logic       V_in,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] ALUop,
  output logic       Z_out,
  output logic       N_out,
  output logic       V_out
);

  state_t     state_reg, state_next;
  logic [2:0] opcode_reg;
  logic [1:0] op_reg;
  logic [2:0] status_q;

  logic is_movi, is_mov, is_alu, is_cmp, is_mvn;

  assign is_movi = (opcode_reg == OPC_MOV) && (op_reg == OP_MOVI);
  assign is_mov  = (opcode_reg == OPC_MOV) && (op_reg == OP_MOV);
  assign is_alu  = (opcode_reg == OPC_ALU);
  assign is_cmp  = is_alu && (op_reg == ALU_CMP);
  assign is_mvn  = is_alu && (op_reg == ALU_MVN);

  // Instruction fields are captured only when a start is accepted, so input
  // changes mid-instruction cannot alter the sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_WAIT;
      opcode_reg <= 3'b000;
      op_reg     <= 2'b00;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_WAIT && s) begin
        opcode_reg <= opcode;
        op_reg     <= op;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    w          = 1'b0;
    nsel       = NSEL_NONE;
    vsel       = VSEL_C;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    write      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    ALUop      = ALU_ADD;

    case (state_reg)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_movi)               state_next = S_WRITE_IMM;
        else if (is_mov || is_mvn) state_next = S_GET_B;
        else if (is_alu)           state_next = S_GET_A;
        else                       state_next = S_WAIT;
      end
      S_GET_A: begin
        nsel       = NSEL_RN;
        loada      = 1'b1;
        state_next = S_GET_B;
      end
      S_GET_B: begin
        nsel       = NSEL_RM;
        loadb      = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        ALUop = is_alu ? op_reg : ALU_ADD;
        asel  = is_mov;
        // CMP only updates flags; every other instruction goes on to writeback.
        if (is_cmp) begin
          loads      = 1'b1;
          state_next = S_WAIT;
        end else begin
          loadc      = 1'b1;
          state_next = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        nsel       = NSEL_RD;
        vsel       = VSEL_C;
        write      = 1'b1;
        state_next = S_WAIT;
      end
      S_WRITE_IMM: begin
        nsel       = NSEL_RN;
        vsel       = VSEL_IMM;
        write      = 1'b1;
        state_next = S_WAIT;
      end
      default: state_next = S_WAIT;
    endcase
  end

  srm_status_reg #(.WIDTH(3)) u_status (
    .clk   (clk),
    .reset (reset),
    .load  (loads),
    .d     ({Z_in, N_in, V_in}),
    .q     (status_q)
  );

  assign Z_out = status_q[2];
  assign N_out = status_q[1];
  assign V_out = status_q[0];

endmodule

// File: tb/tb_srm_controller.sv
// Directed cycle-by-cycle bench for srm_controller: a vector table of per-edge
// inputs and expected Moore outputs, plus a hand-written mid-instruction reset.
module tb_srm_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       Z_in, N_in, V_in;
  logic       w;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       loada, loadb, loadc, loads, write, asel, bsel;
  logic [1:0] ALUop;
  logic       Z_out, N_out, V_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  srm_controller dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .opcode(opcode),
    .op    (op),
    .Z_in  (Z_in),
    .N_in  (N_in),
    .V_in  (V_in),
    .w     (w),
    .nsel  (nsel),
    .vsel  (vsel),
    .loada (loada),
    .loadb (loadb),
    .loadc (loadc),
    .loads (loads),
    .write (write),
    .asel  (asel),
    .bsel  (bsel),
    .ALUop (ALUop),
    .Z_out (Z_out),
    .N_out (N_out),
    .V_out (V_out)
  );

  // ctl = {w, nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel, ALUop}
  localparam logic [14:0] C_WAIT  = {1'b1, 3'b000, 2'b00, 7'b0000000, 2'b00};
  localparam logic [14:0] C_DEC   = {1'b0, 3'b000, 2'b00, 7'b0000000, 2'b00};
  localparam logic [14:0] C_GETA  = {1'b0, 3'b001, 2'b00, 7'b1000000, 2'b00};
  localparam logic [14:0] C_GETB  = {1'b0, 3'b100, 2'b00, 7'b0100000, 2'b00};
  localparam logic [14:0] C_X_ADD = {1'b0, 3'b000, 2'b00, 7'b0010000, 2'b00};
  localparam logic [14:0] C_X_CMP = {1'b0, 3'b000, 2'b00, 7'b0001000, 2'b01};
  localparam logic [14:0] C_X_AND = {1'b0, 3'b000, 2'b00, 7'b0010000, 2'b10};
  localparam logic [14:0] C_X_MVN = {1'b0, 3'b000, 2'b00, 7'b0010000, 2'b11};
  localparam logic [14:0] C_X_MOV = {1'b0, 3'b000, 2'b00, 7'b0010010, 2'b00};
  localparam logic [14:0] C_WREG  = {1'b0, 3'b010, 2'b00, 7'b0000100, 2'b00};
  localparam logic [14:0] C_WIMM  = {1'b0, 3'b001, 2'b10, 7'b0000100, 2'b00};

  typedef struct {
    logic        s;
    logic [2:0]  opc;
    logic [1:0]  op;
    logic [2:0]  znv_in;
    logic [14:0] ctl;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] ctl_now();
    return {w, nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel, ALUop};
  endfunction

  task automatic add(input logic sv, input logic [2:0] oc, input logic [1:0] o,
                     input logic [2:0] zi, input logic [14:0] c, input logic [2:0] f);
    vecs.push_back('{s: sv, opc: oc, op: o, znv_in: zi, ctl: c, flags: f});
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later and compare.
  task automatic step(input string tag, input logic rst, input logic sv,
                      input logic [2:0] oc, input logic [1:0] o, input logic [2:0] zi,
                      input logic [14:0] ectl, input logic [2:0] eflg);
    logic [14:0] act;
    logic [2:0]  aflg;
    reset  = rst;
    s      = sv;
    opcode = oc;
    op     = o;
    {Z_in, N_in, V_in} = zi;
    @(posedge clk);
    #1;
    act  = ctl_now();
    aflg = {Z_out, N_out, V_out};
    checks++;
    if (act !== ectl || aflg !== eflg) begin
      errors++;
      $display("FAIL %s: ctl=%b znv=%b, expected ctl=%b znv=%b", tag, act, aflg, ectl, eflg);
    end else begin
      $display("ok   %s: ctl=%b znv=%b", tag, act, aflg);
    end
  endtask

  initial begin
    reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
    {Z_in, N_in, V_in} = 3'b000;

    // MOVI, single-cycle start pulse
    add(1, 3'b110, 2'b10, 3'b000, C_DEC,   3'b000);
    add(0, 3'b110, 2'b10, 3'b000, C_WIMM,  3'b000);
    add(0, 3'b110, 2'b10, 3'b000, C_WAIT,  3'b000);
    // ADD, with live ALU flags that must not be captured
    add(1, 3'b101, 2'b00, 3'b000, C_DEC,   3'b000);
    add(0, 3'b101, 2'b00, 3'b000, C_GETA,  3'b000);
    add(0, 3'b101, 2'b00, 3'b000, C_GETB,  3'b000);
    add(0, 3'b101, 2'b00, 3'b111, C_X_ADD, 3'b000);
    add(0, 3'b101, 2'b00, 3'b111, C_WREG,  3'b000);
    add(0, 3'b101, 2'b00, 3'b000, C_WAIT,  3'b000);
    // CMP capturing Z=0 N=1 V=1
    add(1, 3'b101, 2'b01, 3'b000, C_DEC,   3'b000);
    add(0, 3'b101, 2'b01, 3'b000, C_GETA,  3'b000);
    add(0, 3'b101, 2'b01, 3'b000, C_GETB,  3'b000);
    add(0, 3'b101, 2'b01, 3'b000, C_X_CMP, 3'b000);
    add(0, 3'b101, 2'b01, 3'b011, C_WAIT,  3'b011);
    // MOV, opcode input changes to 111 after the start is accepted
    add(1, 3'b110, 2'b00, 3'b000, C_DEC,   3'b011);
    add(0, 3'b111, 2'b11, 3'b000, C_GETB,  3'b011);
    add(0, 3'b111, 2'b11, 3'b100, C_X_MOV, 3'b011);
    add(0, 3'b111, 2'b11, 3'b100, C_WREG,  3'b011);
    add(0, 3'b111, 2'b11, 3'b000, C_WAIT,  3'b011);
    // Illegal opcode: DECODE then straight back to WAIT
    add(1, 3'b000, 2'b00, 3'b000, C_DEC,   3'b011);
    add(0, 3'b000, 2'b00, 3'b000, C_WAIT,  3'b011);
    // MVN with s held high, then an AND starting back-to-back
    add(1, 3'b101, 2'b11, 3'b000, C_DEC,   3'b011);
    add(1, 3'b101, 2'b11, 3'b000, C_GETB,  3'b011);
    add(1, 3'b101, 2'b11, 3'b000, C_X_MVN, 3'b011);
    add(1, 3'b101, 2'b11, 3'b111, C_WREG,  3'b011);
    add(1, 3'b101, 2'b11, 3'b000, C_WAIT,  3'b011);
    add(1, 3'b101, 2'b10, 3'b000, C_DEC,   3'b011);
    add(0, 3'b101, 2'b10, 3'b000, C_GETA,  3'b011);
    add(0, 3'b101, 2'b10, 3'b000, C_GETB,  3'b011);
    add(0, 3'b101, 2'b10, 3'b000, C_X_AND, 3'b011);
    add(0, 3'b101, 2'b10, 3'b000, C_WREG,  3'b011);
    add(0, 3'b101, 2'b10, 3'b000, C_WAIT,  3'b011);
    // Second CMP capturing only Z
    add(1, 3'b101, 2'b01, 3'b000, C_DEC,   3'b011);
    add(0, 3'b101, 2'b01, 3'b000, C_GETA,  3'b011);
    add(0, 3'b101, 2'b01, 3'b000, C_GETB,  3'b011);
    add(0, 3'b101, 2'b01, 3'b000, C_X_CMP, 3'b011);
    add(0, 3'b101, 2'b01, 3'b100, C_WAIT,  3'b100);

    step("reset", 1'b1, 1'b0, 3'b000, 2'b00, 3'b000, C_WAIT, 3'b000);
    step("idle",  1'b0, 1'b0, 3'b000, 2'b00, 3'b000, C_WAIT, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), 1'b0, vecs[i].s, vecs[i].opc, vecs[i].op,
           vecs[i].znv_in, vecs[i].ctl, vecs[i].flags);
    end

    // Reset in the middle of an ADD (in GET_B): flags clear, no write pulse
    step("rst_add_dec",  1'b0, 1'b1, 3'b101, 2'b00, 3'b000, C_DEC,  3'b100);
    step("rst_add_geta", 1'b0, 1'b0, 3'b101, 2'b00, 3'b000, C_GETA, 3'b100);
    step("rst_add_getb", 1'b0, 1'b0, 3'b101, 2'b00, 3'b000, C_GETB, 3'b100);
    step("rst_hit",      1'b1, 1'b0, 3'b101, 2'b00, 3'b111, C_WAIT, 3'b000);
    step("rst_with_s",   1'b1, 1'b1, 3'b101, 2'b00, 3'b111, C_WAIT, 3'b000);
    step("rst_release",  1'b0, 1'b0, 3'b101, 2'b00, 3'b111, C_WAIT, 3'b000);
    step("rst_stay",     1'b0, 1'b0, 3'b101, 2'b00, 3'b111, C_WAIT, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
